// File: rtl/ic74165_piso_pkg.sv
// Shared definitions for the 74165-style parallel-in/serial-out block:
// FSM state encoding and the default word width.
package ic74165_piso_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/ic74165_piso_if.sv
// Load handshake, shift control and serial outputs of the PISO block.
// master = the side that supplies words and shift ticks; slave = the PISO.
interface ic74165_piso_if import ic74165_piso_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic [WIDTH-1:0] data;
  logic             load_valid;
  logic             load_ready;
  logic             shift_en;
  logic             ser;
  logic             q;
  logic             q_n;
  logic             busy;
  logic             done;

  modport master (
    output data, load_valid, shift_en, ser,
    input  load_ready, q, q_n, busy, done
  );

  modport slave (
    input  data, load_valid, shift_en, ser,
    output load_ready, q, q_n, busy, done
  );

endinterface

// File: rtl/ic74xx_bit_counter.sv
// Saturating bit counter with synchronous clear; tc flags the enable that
// brings the count to WIDTH, so the caller can finish on that same edge.
module ic74xx_bit_counter import ic74165_piso_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (en && (count_reg != CW'(WIDTH))) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign tc = en && !clr && (count_reg == CW'(WIDTH - 1));

endmodule

// File: rtl/ic74165_piso.sv
// 74165-style serializer: captures a parallel word in IDLE, then shifts it
// out one bit per shift_en tick, filling the vacated end from ser.
module ic74165_piso import ic74165_piso_pkg::*; #(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input logic           clk,
  input logic           rst,
  ic74165_piso_if.slave bus
);

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic [WIDTH-1:0] shifted;
  logic             done_reg;
  logic             done_next;
  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_tc;
  logic             q_bit;

  // Each bit takes its neighbour on the far side from the output end;
  // the end furthest from the output is refilled from ser.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    if (MSB_FIRST != 0) begin : g_msb
      if (gi == 0) begin : g_fill
        assign shifted[gi] = bus.ser;
      end else begin : g_move
        assign shifted[gi] = shift_reg[gi-1];
      end
    end else begin : g_lsb
      if (gi == WIDTH - 1) begin : g_fill
        assign shifted[gi] = bus.ser;
      end else begin : g_move
        assign shifted[gi] = shift_reg[gi+1];
      end
    end
  end

  if (MSB_FIRST != 0) begin : g_out_msb
    assign q_bit = shift_reg[WIDTH-1];
  end else begin : g_out_lsb
    assign q_bit = shift_reg[0];
  end

  ic74xx_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (cnt_tc)
  );

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    done_next  = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    case (state_reg)
      IDLE: begin
        // shift_en is deliberately ignored here, so a coincident load wins
        if (bus.load_valid) begin
          shift_next = bus.data;
          cnt_clr    = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.shift_en) begin
          shift_next = shifted;
          cnt_en     = 1'b1;
          if (cnt_tc) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      done_reg  <= done_next;
    end
  end

  assign bus.load_ready = (state_reg == IDLE);
  assign bus.busy       = (state_reg == SHIFT);
  assign bus.done       = done_reg;
  assign bus.q          = q_bit;
  assign bus.q_n        = ~q_bit;

endmodule

// File: tb/tb_ic74165_piso.sv
// Bench: an MSB-first and an LSB-first instance share one stimulus stream and
// are compared every cycle against a bit-queue model, plus directed literal checks.
module tb_ic74165_piso;
  import ic74165_piso_pkg::*;

  localparam int W = DEFAULT_WIDTH;

  logic         clk = 1'b0;
  logic         rst;
  logic         lv;
  logic         se;
  logic         ser_r;
  logic [W-1:0] data_r;

  always #5 clk = ~clk;

  ic74165_piso_if #(.WIDTH(W)) if0 ();
  ic74165_piso_if #(.WIDTH(W)) if1 ();

  assign if0.data       = data_r;
  assign if0.load_valid = lv;
  assign if0.shift_en   = se;
  assign if0.ser        = ser_r;
  assign if1.data       = data_r;
  assign if1.load_valid = lv;
  assign if1.shift_en   = se;
  assign if1.ser        = ser_r;

  ic74165_piso #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
    .clk (clk),
    .rst (rst),
    .bus (if0.slave)
  );

  ic74165_piso #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: the word is a queue of bits in the order they leave q.
  bit mvalid = 1'b0;
  bit mbusy  = 1'b0;
  bit mdone  = 1'b0;
  int mshifts = 0;
  bit q_msb[$];
  bit q_lsb[$];

  initial forever begin
    @(posedge clk);
    if (rst) begin
      mvalid = 1'b1;
      mbusy = 1'b0;
      mdone = 1'b0;
      mshifts = 0;
      q_msb.delete();
      q_lsb.delete();
      for (int i = 0; i < W; i++) begin
        q_msb.push_back(1'b0);
        q_lsb.push_back(1'b0);
      end
    end else begin
      mdone = 1'b0;
      if (!mbusy) begin
        if (lv) begin
          q_msb.delete();
          q_lsb.delete();
          for (int i = 0; i < W; i++) begin
            q_msb.push_back(data_r[W-1-i]);
            q_lsb.push_back(data_r[i]);
          end
          mbusy = 1'b1;
          mshifts = 0;
        end
      end else if (se) begin
        void'(q_msb.pop_front());
        void'(q_lsb.pop_front());
        q_msb.push_back(ser_r);
        q_lsb.push_back(ser_r);
        mshifts++;
        if (mshifts == W) begin
          mbusy = 1'b0;
          mdone = 1'b1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (mvalid) begin
      check("q_msb",     if0.q,          q_msb[0]);
      check("qn_msb",    if0.q_n,        !q_msb[0]);
      check("q_lsb",     if1.q,          q_lsb[0]);
      check("qn_lsb",    if1.q_n,        !q_lsb[0]);
      check("busy_msb",  if0.busy,       mbusy);
      check("ready_msb", if0.load_ready, !mbusy);
      check("done_msb",  if0.done,       mdone);
      check("busy_lsb",  if1.busy,       mbusy);
      check("ready_lsb", if1.load_ready, !mbusy);
      check("done_lsb",  if1.done,       mdone);
      if (if0.done === 1'b1) done_seen++;
    end
  end

  task automatic cyc(input logic l, input logic [W-1:0] d, input logic s,
                     input logic sr, input logic r);
    lv = l;
    data_r = d;
    se = s;
    ser_r = sr;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  pat;
  logic [15:0] rec;
  int          busy_cnt;
  int          nrec;

  initial begin
    // Reset
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'hFF, 1'b1, 1'b1, 1'b1);
    check("rst_q",     if0.q, 1'b0);
    check("rst_qn",    if0.q_n, 1'b1);
    check("rst_busy",  if0.busy, 1'b0);
    check("rst_ready", if0.load_ready, 1'b1);
    check("rst_done",  if0.done, 1'b0);

    // Basic MSB-first shift, tick every 4th cycle, ser=1
    pat = 8'hA5;
    cyc(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0);
    check("a5_q0", if0.q, pat[7]);
    for (int k = 1; k <= 8; k++) begin
      repeat (3) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
      if (k < 8) check("a5_q", if0.q, pat[7-k]);
    end
    check("a5_done", if0.done, 1'b1);
    check("a5_fill", if0.q, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("a5_done_end", if0.done, 1'b0);
    check("a5_hold", if0.q, 1'b1);

    // LSB-first, shift_en held high (load coincides with shift_en), ser=0
    busy_cnt = 0;
    cyc(1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
    check("coll_lsb_q", if1.q, 1'b1);
    check("coll_msb_q", if0.q, 1'b0);
    busy_cnt += int'(if1.busy);
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check("lsb_q", if1.q, 1'b0);
      busy_cnt += int'(if1.busy);
    end
    check("lsb_busy_cycles", 16'(busy_cnt), 16'd8);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Mid-word load attempt is ignored
    pat = 8'h3C;
    cyc(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    check("3c_q0", if0.q, pat[7]);
    for (int k = 1; k <= 7; k++) begin
      cyc((k >= 3 && k <= 5), 8'hFF, 1'b1, 1'b0, 1'b0);
      check("3c_q", if0.q, pat[7-k]);
    end
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("3c_done", if0.done, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("3c_idle", if0.busy, 1'b0);

    // Back-to-back words, second load taken in the done cycle
    done_seen = 0;
    rec = '0;
    nrec = 0;
    cyc(1'b1, 8'hF0, 1'b0, 1'b1, 1'b0);
    rec[15-nrec] = if0.q; nrec++;
    repeat (7) begin
      cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
      rec[15-nrec] = if0.q; nrec++;
    end
    cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("b2b_done1", if0.done, 1'b1);
    cyc(1'b1, 8'h0F, 1'b1, 1'b1, 1'b0);
    rec[15-nrec] = if0.q; nrec++;
    repeat (7) begin
      cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
      rec[15-nrec] = if0.q; nrec++;
    end
    cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("b2b_done2", if0.done, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("b2b_bits", rec, 16'b1111000000001111);
    check("b2b_done_count", 16'(done_seen), 16'd2);

    // Reset mid-word
    cyc(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
    done_seen = 0;
    cyc(1'b0, '0, 1'b1, 1'b1, 1'b1);
    check("mr_q",     if0.q, 1'b0);
    check("mr_qn",    if0.q_n, 1'b1);
    check("mr_busy",  if0.busy, 1'b0);
    check("mr_ready", if0.load_ready, 1'b1);
    check("mr_done",  if0.done, 1'b0);
    repeat (10) cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("mr_no_done", 16'(done_seen), 16'd0);
    check("mr_idle_q", if0.q, 1'b0);

    // Randomized traffic against the model
    repeat (800) begin
      cyc(($urandom_range(0, 3) == 0), W'($urandom), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
    end
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ic74165_piso.md
IC74165_PISO -- requirements
Module: ic74165_piso

Interface
REQ-001 Parameter WIDTH, default 8: number of data bits per word (legal range 2..16).
REQ-002 Parameter MSB_FIRST, default 1: 1 = shift out from bit WIDTH-1 downward; 0 = shift out from bit 0 upward.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 data  input  WIDTH  parallel word to serialize.
REQ-006 load_valid  input  1  data is valid this cycle.
REQ-007 load_ready  output  1  block accepts a word this cycle.
REQ-008 shift_en  input  1  one-cycle shift tick from an external divider; may be held high.
REQ-009 ser  input  1  cascade serial input, shifted into the vacated end of the register.
REQ-010 q  output  1  serial output: the current output-end bit of the shift register (the 74165 QH equivalent).
REQ-011 q_n  output  1  always the inverse of q.
REQ-012 busy  output  1  high while a word is being shifted.
REQ-013 done  output  1  one-cycle pulse when a word is complete.

Function
REQ-014 The FSM has two states: IDLE and SHIFT.
REQ-015 load_ready is 1 in IDLE and 0 in SHIFT; busy is the inverse of load_ready.
REQ-016 Load: in IDLE, when load_valid=1, the block captures data into the shift register, clears the bit counter and enters SHIFT on the next edge.
REQ-017 Output timing: the first output bit appears on q in the cycle after the load edge (load-to-q latency is one cycle).
REQ-018 Shift: in SHIFT, each cycle with shift_en=1 moves the register one position toward the output end, loads ser into the vacated end and increments the counter.
REQ-019 In SHIFT, a cycle with shift_en=0 holds all state.
REQ-020 On the WIDTH-th shift_en in SHIFT, the FSM returns to IDLE; done=1 for exactly the next cycle, and load_ready=1 in that same cycle.
REQ-021 q is combinational from the output-end register bit, so q shows the new value in the cycle after each shift edge.
REQ-022 In IDLE, shift_en is ignored; the register and q hold their values.
REQ-023 load_valid while busy=1 is ignored; data is not captured and is not queued.
REQ-024 If load_valid=1 and shift_en=1 in the same IDLE cycle, the load wins and that shift_en is discarded.
REQ-025 Back-to-back operation: a load accepted in the done cycle starts the next word; there are no dead cycles beyond the done cycle.
REQ-026 The counter width is clog2(WIDTH+1) bits and never wraps within a word.

Reset
REQ-027 While rst=1: FSM=IDLE, register=0, counter=0, q=0, q_n=1, done=0, busy=0, load_ready=1.
REQ-028 rst takes priority over load_valid and shift_en in the same cycle.
REQ-029 rst during SHIFT aborts the word with no done pulse; the first cycle after rst deasserts is IDLE.

Structure
REQ-030 The shared package holds the FSM state encoding (IDLE=0, SHIFT=1) and the default WIDTH constant.
REQ-031 The bit counter is one sub-module, ic74xx_bit_counter, with synchronous clear, enable and a terminal-count output at WIDTH.
REQ-032 The shift register and FSM live in ic74165_piso.

Verification
REQ-033 Basic shift: WIDTH=8, MSB_FIRST=1, load 0xA5, shift_en every 4th cycle, ser=1 -> q sequence 1,0,1,0,0,1,0,1; done pulses once, 1 cycle after the 8th shift_en; the register then reads 0xFF.
REQ-034 LSB-first: MSB_FIRST=0, load 0x01, shift_en held high, ser=0 -> q sequence 1,0,0,0,0,0,0,0; busy is high for exactly 8 cycles.
REQ-035 Collisions: load 0x3C, then assert load_valid with 0xFF mid-word -> 0xFF is ignored and the q sequence is 0,0,1,1,1,1,0,0; load_valid and shift_en together in IDLE -> the load is taken and q equals data's first bit.
REQ-036 Back-to-back: load 0xF0, then load 0x0F in the done cycle -> 16 contiguous bits 1111000000001111; done pulses exactly twice.
REQ-037 Reset mid-word: assert rst after 3 shifts of 0xAA -> q=0, q_n=1, busy=0, load_ready=1, and no done pulse, checked from the cycle after the rst edge.
REQ-038 Invariant: q_n equals the inverse of q in every cycle of every scenario above.
